// File: rtl/wb_port_arbiter_if.sv
// Write-port bundle shared by the pipeline WB stage, the auxiliary unit and the register file.
interface wb_port_arbiter_if;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 16;

  logic              pipe_wb_en_i;
  logic [REG_W-1:0]  pipe_dest_i;
  logic [DATA_W-1:0] pipe_val_i;
  logic              aux_req_i;
  logic [REG_W-1:0]  aux_dest_i;
  logic [DATA_W-1:0] aux_val_i;
  logic              aux_ack_o;
  logic              rf_wb_en_o;
  logic [REG_W-1:0]  rf_dest_o;
  logic [DATA_W-1:0] rf_val_o;
  logic              stall_o;
  logic [NREGS-1:0]  busy_mask_o;

  modport slave (
    input  pipe_wb_en_i, pipe_dest_i, pipe_val_i,
    input  aux_req_i, aux_dest_i, aux_val_i,
    output aux_ack_o, rf_wb_en_o, rf_dest_o, rf_val_o, stall_o, busy_mask_o
  );

  modport master (
    output pipe_wb_en_i, pipe_dest_i, pipe_val_i,
    output aux_req_i, aux_dest_i, aux_val_i,
    input  aux_ack_o, rf_wb_en_o, rf_dest_o, rf_val_o, stall_o, busy_mask_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline and a small aux write FIFO.
// Optional starvation guard (forced one-cycle drain stall) enabled by macro WB_ARB_STARVE_EN.
module wb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned SCNT_W = 4;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_port_arbiter: FIFO_DEPTH must be a power of two in 2..8");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("wb_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic [REG_W-1:0]      dest_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     val_q  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic              stall_c;
  logic              not_empty_c;
  logic              aux_ack_c;
  logic              push_c;
  logic              grant_pipe_c;
  logic              pop_c;
  logic              rf_wb_en_c;
  logic [REG_W-1:0]  rf_dest_c;
  logic [DATA_W-1:0] rf_val_c;
  logic [NREGS-1:0]  busy_mask_c;

  // A push lands in the FIFO only; the head is never bypassed to the write port.
  assign not_empty_c  = (count_q != '0);
  assign aux_ack_c    = rst && (count_q < CNT_W'(FIFO_DEPTH));
  assign push_c       = bus.aux_req_i && aux_ack_c;
  assign grant_pipe_c = rst && bus.pipe_wb_en_i && !stall_c;
  assign pop_c        = rst && !grant_pipe_c && not_empty_c;

  always_comb begin
    rf_wb_en_c = 1'b0;
    rf_dest_c  = '0;
    rf_val_c   = '0;
    if (grant_pipe_c) begin
      rf_wb_en_c = 1'b1;
      rf_dest_c  = bus.pipe_dest_i;
      rf_val_c   = bus.pipe_val_i;
    end else if (pop_c) begin
      rf_wb_en_c = 1'b1;
      rf_dest_c  = dest_q[rd_ptr_q];
      rf_val_c   = val_q[rd_ptr_q];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop_c) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push_c) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset: the valid bits and count gate every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      dest_q[wr_ptr_q] <= bus.aux_dest_i;
      val_q[wr_ptr_q]  <= bus.aux_val_i;
    end
  end

  always_comb begin
    busy_mask_c = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (valid_q[PTR_W'(i)]) busy_mask_c[dest_q[PTR_W'(i)]] = 1'b1;
    end
  end

`ifdef WB_ARB_STARVE_EN
  logic [SCNT_W-1:0] starve_q, starve_d;
  logic              stall_q, stall_d;

  // Count pipeline wins over a waiting head; a completed stall or an empty FIFO restarts it.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (stall_q || !not_empty_c) begin
      starve_d = '0;
    end else if (grant_pipe_c && (starve_q != SCNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SCNT_W'(1);
    end
    stall_d = !stall_q && (starve_d == SCNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_c = stall_q;
`else
  assign stall_c = 1'b0;
`endif

  assign bus.aux_ack_o   = aux_ack_c;
  assign bus.rf_wb_en_o  = rf_wb_en_c;
  assign bus.rf_dest_o   = rf_dest_c;
  assign bus.rf_val_o    = rf_val_c;
  assign bus.stall_o     = stall_c;
  assign bus.busy_mask_o = busy_mask_c;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus FIFO scoreboard and corner sequences.
module tb_wb_port_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] val;
  } entry_t;

  typedef struct {
    logic        pipe_en;
    logic [3:0]  pdest;
    logic [31:0] pval;
    logic        aux_req;
    logic [3:0]  adest;
    logic [31:0] aval;
    logic        exp_ack;
    logic        exp_wb;
    logic [3:0]  exp_dest;
    logic [31:0] exp_val;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  entry_t sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  logic   m_stall  = 1'b0;
`ifdef WB_ARB_STARVE_EN
  int     m_cnt    = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pe, input logic [3:0] pd, input logic [31:0] pv,
                       input logic ar, input logic [3:0] ad, input logic [31:0] av);
    bus.pipe_wb_en_i = pe;
    bus.pipe_dest_i  = pd;
    bus.pipe_val_i   = pv;
    bus.aux_req_i    = ar;
    bus.aux_dest_i   = ad;
    bus.aux_val_i    = av;
  endtask

  // One cycle: sample at negedge, check against the scoreboard model, then advance past the edge.
  task automatic step(output logic o_ack, output logic o_wb, output logic [3:0] o_dest,
                      output logic [31:0] o_val, output logic o_stall);
    entry_t      head;
    entry_t      e;
    logic        exp_ack;
    logic        gp;
    logic [15:0] exp_mask;
    int          occ;
    @(negedge clk);
    o_ack    = bus.aux_ack_o;
    o_wb     = bus.rf_wb_en_o;
    o_dest   = bus.rf_dest_o;
    o_val    = bus.rf_val_o;
    o_stall  = bus.stall_o;
    occ      = sb_q.size();
    exp_ack  = (occ < int'(DEPTH));
    gp       = bus.pipe_wb_en_i && !m_stall;
    exp_mask = '0;
    foreach (sb_q[i]) exp_mask[sb_q[i].dest] = 1'b1;
    chk("aux_ack", 32'(o_ack), 32'(exp_ack));
    chk("stall", 32'(o_stall), 32'(m_stall));
    chk("busy_mask", 32'(bus.busy_mask_o), 32'(exp_mask));
    if (gp) begin
      chk("pipe_wb_en", 32'(o_wb), 32'd1);
      chk("pipe_dest", 32'(o_dest), 32'(bus.pipe_dest_i));
      chk("pipe_val", o_val, bus.pipe_val_i);
    end else if (occ > 0) begin
      head = sb_q.pop_front();
      chk("buf_wb_en", 32'(o_wb), 32'd1);
      chk("buf_dest", 32'(o_dest), 32'(head.dest));
      chk("buf_val", o_val, head.val);
    end else begin
      chk("idle_wb_en", 32'(o_wb), 32'd0);
      chk("idle_dest", 32'(o_dest), 32'd0);
      chk("idle_val", o_val, 32'd0);
    end
`ifdef WB_ARB_STARVE_EN
    if (m_stall || occ == 0) m_cnt = 0;
    else if (gp && m_cnt < int'(LIMIT)) m_cnt++;
    m_stall = !m_stall && (m_cnt == int'(LIMIT));
`endif
    if (bus.aux_req_i && exp_ack) begin
      e.dest = bus.aux_dest_i;
      e.val  = bus.aux_val_i;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic pe, input logic [3:0] pd, input logic [31:0] pv,
                              input logic ar, input logic [3:0] ad, input logic [31:0] av,
                              input logic ea, input logic ew, input logic [3:0] ed,
                              input logic [31:0] ev);
    vec_t v;
    v.pipe_en = pe; v.pdest = pd; v.pval = pv;
    v.aux_req = ar; v.adest = ad; v.aval = av;
    v.exp_ack = ea; v.exp_wb = ew; v.exp_dest = ed; v.exp_val = ev;
    return v;
  endfunction

  initial begin
    vec_t        tbl[12];
    logic        a, w, s;
    logic [3:0]  d;
    logic [31:0] v;

    // Single push drains next cycle; then pipe-every-cycle fill until the FIFO refuses.
    tbl[0]  = mk(0, 4'd0, 32'h0,  1, 4'd3, 32'hAAAA_0001, 1, 0, 4'd0, 32'h0);
    tbl[1]  = mk(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,         1, 1, 4'd3, 32'hAAAA_0001);
    tbl[2]  = mk(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0);
    tbl[3]  = mk(1, 4'd1, 32'h11, 1, 4'd5, 32'h55,        1, 1, 4'd1, 32'h11);
    tbl[4]  = mk(1, 4'd1, 32'h11, 1, 4'd6, 32'h66,        1, 1, 4'd1, 32'h11);
    tbl[5]  = mk(1, 4'd1, 32'h11, 1, 4'd7, 32'h77,        0, 1, 4'd1, 32'h11);
    tbl[6]  = mk(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,         0, 1, 4'd5, 32'h55);
    tbl[7]  = mk(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,         1, 1, 4'd6, 32'h66);
    tbl[8]  = mk(0, 4'd0, 32'h0,  1, 4'd7, 32'h77,        1, 0, 4'd0, 32'h0);
    tbl[9]  = mk(1, 4'd2, 32'h22, 0, 4'd0, 32'h0,         1, 1, 4'd2, 32'h22);
    tbl[10] = mk(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,         1, 1, 4'd7, 32'h77);
    tbl[11] = mk(0, 4'd0, 32'h0,  0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0);

    // Outputs held quiet while in reset, even with requests asserted.
    rst = 1'b0;
    drive(1, 4'd4, 32'h4444, 1, 4'd4, 32'h4444);
    @(negedge clk);
    chk("rst_aux_ack", 32'(bus.aux_ack_o), 32'd0);
    chk("rst_wb_en", 32'(bus.rf_wb_en_o), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_busy_mask", 32'(bus.busy_mask_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].pipe_en, tbl[i].pdest, tbl[i].pval, tbl[i].aux_req, tbl[i].adest, tbl[i].aval);
      step(a, w, d, v, s);
      chk($sformatf("vec%0d_ack", i), 32'(a), 32'(tbl[i].exp_ack));
      chk($sformatf("vec%0d_wb", i), 32'(w), 32'(tbl[i].exp_wb));
      chk($sformatf("vec%0d_dest", i), 32'(d), 32'(tbl[i].exp_dest));
      chk($sformatf("vec%0d_val", i), v, tbl[i].exp_val);
    end

    // Full FIFO: a request in the popping cycle is refused, the following one accepted.
    drive(1, 4'd1, 32'h11, 1, 4'd8, 32'hA0);  step(a, w, d, v, s);
    drive(1, 4'd1, 32'h11, 1, 4'd9, 32'hB0);  step(a, w, d, v, s);
    drive(0, 4'd0, 32'h0,  1, 4'd10, 32'hC0); step(a, w, d, v, s);
    chk("full_pop_ack", 32'(a), 32'd0);
    chk("full_pop_val", v, 32'hA0);
    step(a, w, d, v, s);
    chk("after_pop_ack", 32'(a), 32'd1);
    chk("after_pop_val", v, 32'hB0);
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    step(a, w, d, v, s);
    chk("late_entry_val", v, 32'hC0);
    step(a, w, d, v, s);

    // Five entries streamed through the two-slot FIFO keep their order across pointer wrap.
    for (int k = 1; k <= 5; k++) begin
      drive(0, 4'd0, 32'h0, 1, 4'(k), 32'(k));
      step(a, w, d, v, s);
      if (k == 1) chk("wrap_first_idle", 32'(w), 32'd0);
      else        chk($sformatf("wrap_order%0d", k - 1), v, 32'(k - 1));
    end
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    step(a, w, d, v, s);
    chk("wrap_order5", v, 32'd5);
    step(a, w, d, v, s);

`ifdef WB_ARB_STARVE_EN
    // Continuous pipeline writes starve the head until a one-cycle forced drain.
    drive(1, 4'd1, 32'hC1, 1, 4'd10, 32'hDEAD_000A);
    step(a, w, d, v, s);
    drive(1, 4'd1, 32'hC1, 0, 4'd0, 32'h0);
    for (int k = 0; k < int'(LIMIT); k++) begin
      step(a, w, d, v, s);
      chk($sformatf("starve%0d_stall", k), 32'(s), 32'd0);
      chk($sformatf("starve%0d_val", k), v, 32'hC1);
    end
    step(a, w, d, v, s);
    chk("forced_stall", 32'(s), 32'd1);
    chk("forced_val", v, 32'hDEAD_000A);
    step(a, w, d, v, s);
    chk("post_stall", 32'(s), 32'd0);
    chk("post_stall_val", v, 32'hC1);
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    step(a, w, d, v, s);
`endif

    // Reset asserted mid-drain discards both entries immediately.
    drive(1, 4'd1, 32'h11, 1, 4'd8, 32'h8888_0008); step(a, w, d, v, s);
    drive(1, 4'd1, 32'h11, 1, 4'd9, 32'h9999_0009); step(a, w, d, v, s);
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_busy_mask", 32'(bus.busy_mask_o), 32'd0);
    chk("midrst_stall", 32'(bus.stall_o), 32'd0);
    chk("midrst_aux_ack", 32'(bus.aux_ack_o), 32'd0);
    chk("midrst_wb_en", 32'(bus.rf_wb_en_o), 32'd0);
    @(posedge clk);
    #1;
    sb_q.delete();
    m_stall = 1'b0;
`ifdef WB_ARB_STARVE_EN
    m_cnt = 0;
`endif
    rst = 1'b1;
    step(a, w, d, v, s);
    chk("stale_wb0", 32'(w), 32'd0);
    step(a, w, d, v, s);
    chk("stale_wb1", 32'(w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
